pkhdr_seqr: RTL and testbench
=============================

Name: pkhdr_seqr

Overview:
- Parametrised next-generation access-code/header sequencer for the baseband bit pipe.
- TX: serialises preamble, 64-bit syncword, trailer and FEC-encoded header+HEC.
- RX: starts at the trailer, majority-decodes the header, checks HEC and keeps per-LT_ADDR FLOW/ARQN state.
- Generalised in LT_ADDR width, FEC repetition factor and LT channel count. Adds internal HEC generation/check, majority-vote decoding and abort handling. Whitening stays external.

Parameters:
- LTW, 3, LT_ADDR field width; NUM_LT = 2**LTW channels; HDR_BITS = LTW+7.
- FEC_REP, 3, header repetition factor; odd, legal values 1, 3, 5.

Ports:
- clk_6M  in  1  6 MHz clock
- rstz  in  1  asynchronous active-low reset
- p_1us  in  1  1 us bit strobe; every bit-time action qualifies on it
- tx_start_p  in  1  start TX access code + header
- rx_start_p  in  1  sync correlated; start RX at trailer
- abort_p  in  1  kill current packet
- conn_reset_p  in  1  new connection; reset per-LT state
- edr_mode  in  1  EDR packet (used only with option)
- uap  in  8  HEC LFSR init
- syncword  in  64  access-code syncword, LSB sent first
- tx_header  in  HDR_BITS  {SEQN,ARQN,FLOW,TYPE[3:0],LT[LTW-1:0]}
- my_lt  in  LTW  own LT_ADDR
- rxbit  in  1  de-whitened receive bit
- edr_sync  in  11  EDR sync sequence
- txbit  out  1  serial TX bit
- busy  out  1  packet in progress
- hdr_done_p  out  1  one-clk end-of-header pulse
- dec_header  out  HDR_BITS  decoded header
- dec_hecgood  out  1  HEC matched
- lt_addressed  out  1  good header addressed to my_lt or broadcast (0)
- flow_vec  out  NUM_LT  last FLOW per LT
- arqn_vec  out  NUM_LT  last ARQN per LT
- guard_st_p, edrsync_st_p  out  1  EDR phase starts

Behaviour:
- Reset values: txbit 0, busy 0, hdr_done_p 0, dec_header 0, dec_hecgood 0, lt_addressed 0, flow_vec all 1, arqn_vec all 0; bit counter idle.
- Bit counter cnt (8 bit), advances on p_1us while busy. HEND = 72 + (HDR_BITS+8)*FEC_REP - 1 (125 at defaults).
  - tx_start_p & p_1us: cnt = 0, busy = 1.
  - rx_start_p & p_1us: cnt = 68, busy = 1.
  - Priority: abort_p > tx_start_p > rx_start_p.
- Phases and txbit (combinational from cnt):
  - Preamble, cnt 0..3: syncword[0] ? !cnt[0] : cnt[0].
  - Sync, cnt 4..67: syncword[cnt-4].
  - Trailer, cnt 68..71: syncword[63] ? cnt[0] : !cnt[0].
  - Header, cnt 72..HEND: each logical bit repeated FEC_REP times. Order is HDR_BITS header bits LSB first, then 8 HEC bits.
  - txbit is 0 outside busy.
- HEC:
  - 8-bit LFSR, polynomial x^8+x^7+x^5+x^2+x+1, loaded with uap when cnt == 71.
  - Shifted once per header logical bit (TX input bit, or RX decoded bit).
  - TX sends LFSR contents MSB first after the header bits.
- RX decode:
  - Count 1s over FEC_REP samples; decoded bit = count > FEC_REP/2.
  - Header bits shift into dec_header LSB first.
  - HEC bits are compared against the LFSR; any mismatch clears a good flag.
- End of header:
  - On p_1us with cnt == HEND (no EDR): hdr_done_p = 1 for one clk_6M cycle; busy drops the next cycle.
  - RX only:
    - dec_hecgood <= flag.
    - lt_addressed <= flag & (dec LT == my_lt | dec LT == 0).
    - If lt_addressed condition holds: flow_vec[LT] <= FLOW, arqn_vec[LT] <= ARQN.
  - Results are valid from the cycle after hdr_done_p.
  - A TX packet leaves dec_*, lt_addressed and vectors unchanged, except lt_addressed, which clears on tx_start_p.
- abort_p: busy 0 next cycle; no hdr_done_p; no state update; dec_header keeps its old value.
- conn_reset_p: flow_vec all 1, arqn_vec all 0. It wins over a same-cycle end-of-header update.
- A start while busy restarts the counter; the partial packet is discarded.

Optional Feature:
- PKHDR_EDR_GUARD_EN defined, edr_mode = 1:
  - After HEND the packet continues: guard cnt HEND+1..HEND+5 with txbit 0, then sync HEND+6..HEND+16 with txbit edr_sync[cnt-HEND-6].
  - guard_st_p pulses with p_1us at cnt == HEND; edrsync_st_p pulses at cnt == HEND+5.
  - hdr_done_p moves to cnt == HEND+16 (141 at defaults).
- Undefined: edr_mode and edr_sync are ignored; guard_st_p and edrsync_st_p are tied 0.

Test Plan:
- TX, syncword 64'h1, tx_header 10'h2A5, uap 8'h47, FEC_REP=3 -> preamble 1,0,1,0; then bits 1,0,...,0; trailer 1,0,1,0; each header bit tripled; HEC matches the model; hdr_done_p at cnt 125.
- Loop TX stream into rxbit via rx_start_p at the trailer, my_lt=5 -> dec_header 10'h2A5, dec_hecgood 1, lt_addressed 1, flow_vec[5] and arqn_vec[5] updated.
- Same RX with one flipped sample per triplet -> identical decode; flip 2 of 3 on a HEC bit -> dec_hecgood 0, flow_vec unchanged (all 1).
- RX header with LT=0 and my_lt=3 -> lt_addressed 1 (broadcast); LT=6 -> lt_addressed 0.
- abort_p at cnt 90 -> busy 0 next clk, no hdr_done_p; conn_reset_p coincident with hdr_done_p -> flow_vec 8'hFF, arqn_vec 8'h00.
- With PKHDR_EDR_GUARD_EN, edr_mode=1, edr_sync 11'h5A5 -> txbit 0 at cnt 126..130, edr_sync bits at 131..141, hdr_done_p at 141.

Source files
------------

// File: rtl/pkhdr_seqr.sv
// rtl/pkhdr_seqr.sv - access-code/header sequencer: TX serialiser, RX majority decode, HEC, per-LT FLOW/ARQN
// Optional EDR guard/sync tail enabled by defining PKHDR_EDR_GUARD_EN.
module pkhdr_seqr #(
    parameter int LTW = 3,
    parameter int FEC_REP = 3,
    localparam int NUM_LT = 2**LTW,
    localparam int HDR_BITS = LTW + 7
) (
    input  logic                clk_6M,
    input  logic                rstz,
    input  logic                p_1us,
    input  logic                tx_start_p,
    input  logic                rx_start_p,
    input  logic                abort_p,
    input  logic                conn_reset_p,
    input  logic                edr_mode,
    input  logic [7:0]          uap,
    input  logic [63:0]         syncword,
    input  logic [HDR_BITS-1:0] tx_header,
    input  logic [LTW-1:0]      my_lt,
    input  logic                rxbit,
    input  logic [10:0]         edr_sync,
    output logic                txbit,
    output logic                busy,
    output logic                hdr_done_p,
    output logic [HDR_BITS-1:0] dec_header,
    output logic                dec_hecgood,
    output logic                lt_addressed,
    output logic [NUM_LT-1:0]   flow_vec,
    output logic [NUM_LT-1:0]   arqn_vec,
    output logic                guard_st_p,
    output logic                edrsync_st_p
);

    localparam int NBITS = HDR_BITS + 8;
    localparam int HEND = 72 + NBITS * FEC_REP - 1;
    localparam int BIW = $clog2(NBITS + 1);
    localparam int REPW = $clog2(FEC_REP + 1);
    localparam logic [7:0] HEND_C = 8'(HEND);

    typedef enum logic [1:0] {S_IDLE, S_TX, S_RX} state_t;

    state_t state_q, state_d;

    logic [7:0]          cnt;
    logic [REPW-1:0]     rep_cnt, ones, total;
    logic [BIW-1:0]      bit_idx, hec_idx;
    logic [7:0]          hec, hec_nx, hec_sh, sync_idx;
    logic [63:0]         sync_sh;
    logic [HDR_BITS-1:0] hdr_sr, tx_sh;
    logic [LTW-1:0]      lt_dec;
    logic [7:0]          done_cnt;
    logic good, good_nxt, addr_ok;
    logic tx_go, rx_go, start, tick, end_hit, is_rx;
    logic in_hdr, last_rep, hdr_phase, hec_cmp;
    logic tx_hdr_bit, hec_exp, hdr_bit, dec_bit, in_bit, fb;
    logic edr_bit;

    assign busy  = (state_q != S_IDLE);
    assign is_rx = (state_q == S_RX);

    assign tx_go = p_1us & tx_start_p & ~abort_p;
    assign rx_go = p_1us & rx_start_p & ~abort_p & ~tx_start_p;
    assign start = tx_go | rx_go;
    assign tick  = busy & p_1us & ~abort_p & ~start;

`ifdef PKHDR_EDR_GUARD_EN
    logic [7:0]  edr_idx;
    logic [10:0] edr_sh;
    logic        edr_q;

    assign done_cnt     = edr_q ? 8'(HEND + 16) : HEND_C;
    assign edr_idx      = cnt - 8'(HEND + 6);
    assign edr_sh       = edr_sync >> edr_idx;
    assign edr_bit      = (edr_q && cnt > 8'(HEND + 5)) ? edr_sh[0] : 1'b0;
    assign guard_st_p   = tick & edr_q & (cnt == HEND_C);
    assign edrsync_st_p = tick & edr_q & (cnt == 8'(HEND + 5));
`else
    logic unused_edr;

    assign unused_edr   = ^{edr_mode, edr_sync};
    assign done_cnt     = HEND_C;
    assign edr_bit      = 1'b0;
    assign guard_st_p   = 1'b0;
    assign edrsync_st_p = 1'b0;
`endif

    assign end_hit    = tick & (cnt == done_cnt);
    assign hdr_done_p = end_hit;

    // Header phase bookkeeping: logical bit index and repetition slot within it.
    assign in_hdr    = (cnt >= 8'd72) && (cnt <= HEND_C);
    assign last_rep  = (rep_cnt == REPW'(FEC_REP - 1));
    assign hdr_phase = (bit_idx < BIW'(HDR_BITS));
    assign hec_idx   = bit_idx - BIW'(HDR_BITS);
    assign hec_sh    = hec << hec_idx[2:0];
    assign hec_exp   = hec_sh[7];
    assign tx_sh     = tx_header >> bit_idx;
    assign tx_hdr_bit = tx_sh[0];
    assign hdr_bit   = hdr_phase ? tx_hdr_bit : hec_exp;

    assign total   = ones + REPW'(rxbit);
    assign dec_bit = (total > REPW'(FEC_REP / 2));
    assign in_bit  = is_rx ? dec_bit : tx_hdr_bit;

    assign fb     = hec[7] ^ in_bit;
    assign hec_nx = {hec[6:0], 1'b0} ^ ({8{fb}} & 8'hA7);

    assign hec_cmp  = in_hdr & last_rep & ~hdr_phase;
    assign good_nxt = good & ~(hec_cmp & (dec_bit != hec_exp));
    assign lt_dec   = hdr_sr[LTW-1:0];
    assign addr_ok  = good_nxt & ((lt_dec == my_lt) | (lt_dec == '0));

    assign sync_idx = cnt - 8'd4;
    assign sync_sh  = syncword >> sync_idx;

    always_comb begin
        txbit = 1'b0;
        if (busy) begin
            if (cnt < 8'd4)
                txbit = syncword[0] ? ~cnt[0] : cnt[0];
            else if (cnt < 8'd68)
                txbit = sync_sh[0];
            else if (cnt < 8'd72)
                txbit = syncword[63] ? cnt[0] : ~cnt[0];
            else if (cnt <= HEND_C)
                txbit = hdr_bit;
            else
                txbit = edr_bit;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_p)
            state_d = S_IDLE;
        else if (tx_go)
            state_d = S_TX;
        else if (rx_go)
            state_d = S_RX;
        else if (end_hit)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            cnt          <= 8'd0;
            rep_cnt      <= '0;
            ones         <= '0;
            bit_idx      <= '0;
            hec          <= 8'd0;
            good         <= 1'b0;
            hdr_sr       <= '0;
            dec_header   <= '0;
            dec_hecgood  <= 1'b0;
            lt_addressed <= 1'b0;
            flow_vec     <= '1;
            arqn_vec     <= '0;
`ifdef PKHDR_EDR_GUARD_EN
            edr_q        <= 1'b0;
`endif
        end else begin
            if (start) begin
                cnt     <= tx_go ? 8'd0 : 8'd68;
                rep_cnt <= '0;
                ones    <= '0;
                bit_idx <= '0;
                good    <= 1'b1;
`ifdef PKHDR_EDR_GUARD_EN
                edr_q   <= edr_mode;
`endif
                if (tx_go)
                    lt_addressed <= 1'b0;
            end else if (tick) begin
                cnt <= cnt + 8'd1;
                if (cnt == 8'd71)
                    hec <= uap;
                if (in_hdr) begin
                    if (last_rep) begin
                        rep_cnt <= '0;
                        ones    <= '0;
                        bit_idx <= bit_idx + BIW'(1);
                        if (hdr_phase) begin
                            hec <= hec_nx;
                            if (is_rx)
                                hdr_sr <= {in_bit, hdr_sr[HDR_BITS-1:1]};
                        end else begin
                            good <= good_nxt;
                        end
                    end else begin
                        rep_cnt <= rep_cnt + REPW'(1);
                        ones    <= total;
                    end
                end
                // RX results commit on the same strobe that raises hdr_done_p.
                if (end_hit && is_rx) begin
                    dec_header   <= hdr_sr;
                    dec_hecgood  <= good_nxt;
                    lt_addressed <= addr_ok;
                    if (addr_ok) begin
                        flow_vec[lt_dec] <= hdr_sr[LTW+4];
                        arqn_vec[lt_dec] <= hdr_sr[LTW+5];
                    end
                end
            end
            if (conn_reset_p) begin
                flow_vec <= '1;
                arqn_vec <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pkhdr_seqr.sv
// tb/tb_pkhdr_seqr.sv - self-checking bench for pkhdr_seqr with bit-stream reference model
module tb_pkhdr_seqr;

    localparam int LTW  = 3;
    localparam int FEC  = 3;
    localparam int HB   = 10;
    localparam int NL   = 8;
    localparam int HEND = 125;
`ifdef PKHDR_EDR_GUARD_EN
    localparam bit EDR_ON = 1'b1;
`else
    localparam bit EDR_ON = 1'b0;
`endif

    logic clk_6M = 1'b0;
    logic rstz = 1'b0;
    logic p_1us = 0, tx_start_p = 0, rx_start_p = 0, abort_p = 0, conn_reset_p = 0;
    logic edr_mode = 0, rxbit = 0;
    logic [7:0] uap = 0;
    logic [63:0] syncword = 0;
    logic [HB-1:0] tx_header = 0;
    logic [LTW-1:0] my_lt = 0;
    logic [10:0] edr_sync = 0;
    logic txbit, busy, hdr_done_p, dec_hecgood, lt_addressed, guard_st_p, edrsync_st_p;
    logic [HB-1:0] dec_header;
    logic [NL-1:0] flow_vec, arqn_vec;

    pkhdr_seqr #(.LTW(LTW), .FEC_REP(FEC)) dut (
        .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .tx_start_p(tx_start_p),
        .rx_start_p(rx_start_p), .abort_p(abort_p), .conn_reset_p(conn_reset_p),
        .edr_mode(edr_mode), .uap(uap), .syncword(syncword), .tx_header(tx_header),
        .my_lt(my_lt), .rxbit(rxbit), .edr_sync(edr_sync), .txbit(txbit), .busy(busy),
        .hdr_done_p(hdr_done_p), .dec_header(dec_header), .dec_hecgood(dec_hecgood),
        .lt_addressed(lt_addressed), .flow_vec(flow_vec), .arqn_vec(arqn_vec),
        .guard_st_p(guard_st_p), .edrsync_st_p(edrsync_st_p)
    );

    always #5 clk_6M = ~clk_6M;

    int total = 0, passed = 0;
    logic s_done, s_guard, s_esync;
    logic exp_bits [0:255];
    logic rx_bits [0:255];
    logic [NL-1:0] m_flow, m_arqn;
    logic [HB-1:0] m_dec;
    logic m_good, m_addr;

    typedef struct {
        logic [63:0] sw; logic [HB-1:0] hdr; logic [7:0] u; logic edr; int exp_last;
    } txvec_t;
    typedef struct {
        logic [HB-1:0] hdr; logic [LTW-1:0] mylt; int mode; logic exp_good; logic exp_addr;
    } rxvec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // HEC as polynomial division by x^8+x^7+x^5+x^2+x+1, register seeded with uap.
    function automatic logic [7:0] m_hec(input logic [7:0] u, input logic [HB-1:0] h);
        logic [8:0] r;
        r = {1'b0, u};
        for (int i = 0; i < HB; i++) begin
            r = {r[7:0], 1'b0} ^ {h[i], 8'h00};
            if (r[8]) r = r ^ 9'h1A7;
        end
        return r[7:0];
    endfunction

    task automatic build(input logic [63:0] sw, input logic [HB-1:0] h, input logic [7:0] u,
                         input logic edr, output int last);
        logic [7:0] hc;
        logic b;
        hc = m_hec(u, h);
        for (int c = 0; c < 4; c++) exp_bits[c] = sw[0] ? ((c % 2) == 0) : ((c % 2) == 1);
        for (int c = 4; c < 68; c++) exp_bits[c] = sw[c-4];
        for (int c = 68; c < 72; c++) exp_bits[c] = sw[63] ? ((c % 2) == 1) : ((c % 2) == 0);
        for (int k = 0; k < HB + 8; k++) begin
            b = (k < HB) ? h[k] : hc[7-(k-HB)];
            for (int j = 0; j < FEC; j++) exp_bits[72 + k*FEC + j] = b;
        end
        last = HEND;
        if (EDR_ON && edr) begin
            for (int c = HEND + 1; c <= HEND + 5; c++) exp_bits[c] = 1'b0;
            for (int c = HEND + 6; c <= HEND + 16; c++) exp_bits[c] = edr_sync[c-HEND-6];
            last = HEND + 16;
        end
    endtask

    task automatic strobe(input logic t, input logic r, input logic a, input logic cr);
        p_1us = 1; tx_start_p = t; rx_start_p = r; abort_p = a; conn_reset_p = cr;
        #3;
        s_done = hdr_done_p; s_guard = guard_st_p; s_esync = edrsync_st_p;
        @(posedge clk_6M); #1;
        p_1us = 0; tx_start_p = 0; rx_start_p = 0; abort_p = 0; conn_reset_p = 0;
        @(posedge clk_6M); #1;
    endtask

    task automatic tx_run(input logic [63:0] sw, input logic [HB-1:0] h, input logic [7:0] u,
                          input logic edr, output int done_at);
        int last, berr, gerr;
        syncword = sw; tx_header = h; uap = u; edr_mode = edr;
        build(sw, h, u, edr, last);
        strobe(1, 0, 0, 0);
        berr = 0; gerr = 0; done_at = -1;
        for (int c = 0; c <= last; c++) begin
            if (txbit !== exp_bits[c] || busy !== 1'b1) berr++;
            strobe(0, 0, 0, 0);
            if (s_done === 1'b1 && done_at < 0) done_at = c;
            if (s_guard !== (EDR_ON && edr && c == HEND)) gerr++;
            if (s_esync !== (EDR_ON && edr && c == HEND + 5)) gerr++;
        end
        m_addr = 1'b0;
        chk("tx_stream_errs", berr, 0);
        chk("tx_edr_pulse_errs", gerr, 0);
        chk("tx_busy_after", busy, 0);
        chk("tx_txbit_idle", txbit, 0);
        chk("tx_keeps_dec_header", dec_header, m_dec);
        chk("tx_clears_lt_addr", lt_addressed, 0);
        chk("tx_keeps_flow", flow_vec, m_flow);
    endtask

    task automatic rx_run(input logic [HB-1:0] h, input logic [7:0] u, input logic [LTW-1:0] ml,
                          input int mode, input logic cr);
        int last, derr, ones;
        logic [HB+7:0] d;
        logic [7:0] mc;
        logic [LTW-1:0] lt;
        edr_mode = 0; uap = u; my_lt = ml;
        build(syncword, h, u, 1'b0, last);
        for (int c = 0; c < 256; c++) rx_bits[c] = exp_bits[c];
        for (int k = 0; k < HB + 8; k++) begin
            if (mode == 1) rx_bits[72 + k*FEC + (k % FEC)] = ~rx_bits[72 + k*FEC + (k % FEC)];
            if (mode == 2 && k == HB) begin
                rx_bits[72 + k*FEC] = ~rx_bits[72 + k*FEC];
                rx_bits[73 + k*FEC] = ~rx_bits[73 + k*FEC];
            end
            if (mode == 3)
                for (int j = 0; j < FEC; j++)
                    if ($urandom_range(0, 7) == 0) rx_bits[72 + k*FEC + j] = ~rx_bits[72 + k*FEC + j];
        end
        for (int k = 0; k < HB + 8; k++) begin
            ones = 0;
            for (int j = 0; j < FEC; j++) ones += int'(rx_bits[72 + k*FEC + j]);
            d[k] = (ones > FEC / 2);
        end
        m_dec = d[HB-1:0];
        mc = m_hec(u, m_dec);
        m_good = 1'b1;
        for (int i = 0; i < 8; i++) if (d[HB+i] != mc[7-i]) m_good = 1'b0;
        lt = m_dec[LTW-1:0];
        m_addr = m_good && (lt == ml || lt == 0);
        if (m_addr) begin m_flow[lt] = m_dec[LTW+4]; m_arqn[lt] = m_dec[LTW+5]; end
        if (cr) begin m_flow = '1; m_arqn = '0; end
        strobe(0, 1, 0, 0);
        derr = 0;
        for (int c = 68; c <= last; c++) begin
            rxbit = rx_bits[c];
            strobe(0, 0, 0, cr && c == last);
            if (s_done !== (c == last)) derr++;
        end
        chk("rx_done_pos_errs", derr, 0);
        chk("rx_busy_after", busy, 0);
        chk("rx_dec_header", dec_header, m_dec);
        chk("rx_hecgood", dec_hecgood, m_good);
        chk("rx_lt_addressed", lt_addressed, m_addr);
        chk("rx_flow_vec", flow_vec, m_flow);
        chk("rx_arqn_vec", arqn_vec, m_arqn);
    endtask

    txvec_t txv [4];
    rxvec_t rxv [6];
    int done_at, dcnt;
    logic [HB-1:0] hold_dec;

    initial begin
        txv[0] = '{64'h1, 10'h2A5, 8'h47, 1'b0, HEND};
        txv[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 10'h3FF, 8'h00, 1'b0, HEND};
        txv[2] = '{64'h8000_0000_0000_0000, 10'h000, 8'hFF, 1'b0, HEND};
        txv[3] = '{64'h0123_4567_89AB_CDEF, 10'h155, 8'hA3, 1'b1, EDR_ON ? HEND + 16 : HEND};
        rxv[0] = '{10'h2A5, 3'd5, 0, 1'b1, 1'b1};
        rxv[1] = '{10'h2A5, 3'd5, 1, 1'b1, 1'b1};
        rxv[2] = '{10'h2A5, 3'd5, 2, 1'b0, 1'b0};
        rxv[3] = '{10'h2A0, 3'd3, 0, 1'b1, 1'b1};
        rxv[4] = '{10'h2A6, 3'd3, 0, 1'b1, 1'b0};
        rxv[5] = '{10'h102, 3'd2, 0, 1'b1, 1'b1};

        edr_sync = 11'h5A5;
        repeat (3) @(posedge clk_6M);
        #1 rstz = 1'b1;
        @(posedge clk_6M); #1;
        chk("rst_txbit", txbit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hdr_done", hdr_done_p, 0);
        chk("rst_dec_header", dec_header, 0);
        chk("rst_hecgood_ltaddr", {dec_hecgood, lt_addressed}, 0);
        chk("rst_flow_vec", flow_vec, 8'hFF);
        chk("rst_arqn_vec", arqn_vec, 8'h00);
        m_flow = '1; m_arqn = '0; m_dec = '0; m_good = 0; m_addr = 0;

        for (int i = 0; i < 4; i++) begin
            tx_run(txv[i].sw, txv[i].hdr, txv[i].u, txv[i].edr, done_at);
            chk("tx_done_cnt", done_at, txv[i].exp_last);
        end

        syncword = 64'h1;
        for (int i = 0; i < 6; i++) begin
            rx_run(rxv[i].hdr, 8'h47, rxv[i].mylt, rxv[i].mode, 1'b0);
            chk("tbl_dec_header", dec_header, rxv[i].hdr);
            chk("tbl_hecgood", dec_hecgood, rxv[i].exp_good);
            chk("tbl_lt_addressed", lt_addressed, rxv[i].exp_addr);
        end
        chk("tbl_lt2_flow_arqn", {flow_vec[2], arqn_vec[2]}, 2'b01);

        // TX after an addressed RX clears lt_addressed only.
        tx_run(64'h1, 10'h2A5, 8'h47, 1'b0, done_at);

        // Abort TX at cnt 90: idle next clk, no end-of-header later.
        tx_header = 10'h2A5;
        strobe(1, 0, 0, 0);
        repeat (90) strobe(0, 0, 0, 0);
        abort_p = 1'b1;
        @(posedge clk_6M); #1;
        abort_p = 1'b0;
        chk("abort_busy", busy, 0);
        dcnt = 0;
        for (int i = 0; i < 60; i++) begin strobe(0, 0, 0, 0); if (s_done) dcnt++; end
        chk("abort_no_done", dcnt, 0);
        chk("abort_txbit", txbit, 0);

        // Abort mid-RX keeps previous decode and vectors.
        hold_dec = dec_header;
        strobe(0, 1, 0, 0);
        for (int i = 0; i < 30; i++) begin rxbit = i[0]; strobe(0, 0, 0, 0); end
        strobe(0, 0, 1, 0);
        chk("rx_abort_no_done", s_done, 0);
        chk("rx_abort_busy", busy, 0);
        chk("rx_abort_dec_header", dec_header, hold_dec);
        chk("rx_abort_flow", flow_vec, m_flow);

        // Restart while busy discards the partial packet.
        strobe(1, 0, 0, 0);
        repeat (40) strobe(0, 0, 0, 0);
        tx_run(64'hDEAD_BEEF_0BAD_F00D, 10'h0F3, 8'h5C, 1'b0, done_at);
        chk("restart_done_cnt", done_at, HEND);

        // conn_reset_p on the end-of-header strobe beats the update.
        rx_run(10'h102, 8'h47, 3'd2, 0, 1'b0);
        rx_run(10'h10D, 8'h47, 3'd5, 0, 1'b1);
        chk("connrst_flow", flow_vec, 8'hFF);
        chk("connrst_arqn", arqn_vec, 8'h00);

        for (int n = 0; n < 16; n++) begin
            logic [63:0] sw;
            logic [HB-1:0] h;
            logic [7:0] u;
            sw = {$urandom, $urandom};
            h = HB'($urandom);
            u = 8'($urandom);
            tx_run(sw, h, u, 1'b0, done_at);
            rx_run(h, u, 3'($urandom), 3, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
